// File: rtl/voltage_digit_sequencer.sv
// voltage_digit_sequencer
// Takes one ADC sample per handshake and scales it to millivolts with a single
// registered multiply. It then splits the value into volts, tenths and
// hundredths digits by repeated subtraction (one step per cycle) and presents
// them with a valid/ready handshake. A holdoff counter throttles how often
// samples are accepted, so the display does not flicker.
module voltage_digit_sequencer #(
  parameter int ADC_BITS   = 12,
  parameter int VREF_MV    = 5000,
  parameter int UPDATE_DIV = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADC_BITS-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [3:0]          d_int,
  output logic [3:0]          d_frac1,
  output logic [3:0]          d_frac2,
  output logic [15:0]         d_mv,
  output logic                d_valid,
  input  logic                d_ready,
  output logic                busy
);

  localparam int HW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int PW = ADC_BITS + 13;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    THOU = 3'd2,
    HUND = 3'd3,
    TEN  = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [HW-1:0]       holdoff_r;
  logic [ADC_BITS-1:0] sample_r;
  logic [13:0]         rem_r;
  logic [13:0]         mv_r;
  logic [3:0]          dig0_r;
  logic [3:0]          dig1_r;
  logic [3:0]          dig2_r;

  logic                ready_s;
  logic                accept_s;
  logic [PW-1:0]       prod_s;
  logic [13:0]         mul_mv_s;

  // Handshake decode from registered state only; the full-scale product is truncated, not rounded.
  always_comb begin
    ready_s  = (state_r == IDLE) && (holdoff_r == {HW{1'b0}});
    accept_s = s_valid && ready_s;
    prod_s   = PW'(sample_r) * PW'(VREF_MV);
    mul_mv_s = 14'(prod_s >> ADC_BITS);
  end

  // Status outputs, decoded directly from registers.
  always_comb begin
    s_ready = ready_s;
    busy    = (state_r != IDLE);
  end

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: each subtraction stage stays put while its place value still fits.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = MUL;               else state_s = IDLE;
      MUL:     state_s = THOU;
      THOU:    if (rem_r >= 14'd1000) state_s = THOU;     else state_s = HUND;
      HUND:    if (rem_r >= 14'd100)  state_s = HUND;     else state_s = TEN;
      TEN:     if (rem_r >= 14'd10)   state_s = TEN;      else state_s = OUT;
      OUT:     if (d_ready) state_s = IDLE;               else state_s = OUT;
      default: state_s = IDLE;
    endcase
  end

  // Holdoff throttle: reload on accept, otherwise count down to zero in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdoff_r <= {HW{1'b0}};
    end else if (accept_s) begin
      holdoff_r <= HW'(UPDATE_DIV - 1);
    end else if (holdoff_r != {HW{1'b0}}) begin
      holdoff_r <= holdoff_r - HW'(1);
    end else begin
      holdoff_r <= holdoff_r;
    end
  end

  // Datapath and registered outputs: capture, scale, digit extraction, result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_r <= {ADC_BITS{1'b0}};
      rem_r    <= 14'd0;
      mv_r     <= 14'd0;
      dig0_r   <= 4'd0;
      dig1_r   <= 4'd0;
      dig2_r   <= 4'd0;
      d_int    <= 4'd0;
      d_frac1  <= 4'd0;
      d_frac2  <= 4'd0;
      d_mv     <= 16'd0;
      d_valid  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) sample_r <= s_data;
        end
        MUL: begin
          rem_r  <= mul_mv_s;
          mv_r   <= mul_mv_s;
          dig0_r <= 4'd0;
          dig1_r <= 4'd0;
          dig2_r <= 4'd0;
        end
        THOU: begin
          if (rem_r >= 14'd1000) begin
            rem_r  <= rem_r - 14'd1000;
            dig0_r <= dig0_r + 4'd1;
          end
        end
        HUND: begin
          if (rem_r >= 14'd100) begin
            rem_r  <= rem_r - 14'd100;
            dig1_r <= dig1_r + 4'd1;
          end
        end
        TEN: begin
          if (rem_r >= 14'd10) begin
            rem_r  <= rem_r - 14'd10;
            dig2_r <= dig2_r + 4'd1;
          end else begin
            // Units digit left in rem_r is intentionally dropped.
            d_int   <= dig0_r;
            d_frac1 <= dig1_r;
            d_frac2 <= dig2_r;
            d_mv    <= {2'b00, mv_r};
            d_valid <= 1'b1;
          end
        end
        OUT: begin
          if (d_ready) d_valid <= 1'b0;
        end
        default: begin
          d_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voltage_digit_sequencer.sv
// Directed bench for voltage_digit_sequencer: reset, known conversions and latencies,
// output hold under backpressure, holdoff spacing, and a randomized sweep against a model.
module tb_voltage_digit_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] s_data = 12'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  d_int, d_frac1, d_frac2;
  logic [15:0] d_mv;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic        busy;

  logic [11:0] s_data2 = 12'd0;
  logic        s_valid2 = 1'b0;
  logic        s_ready2;
  logic [3:0]  d_int2, d_frac12, d_frac22;
  logic [15:0] d_mv2;
  logic        d_valid2;
  logic        d_ready2 = 1'b1;
  logic        busy2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  voltage_digit_sequencer dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .d_int(d_int), .d_frac1(d_frac1), .d_frac2(d_frac2), .d_mv(d_mv),
    .d_valid(d_valid), .d_ready(d_ready), .busy(busy)
  );

  voltage_digit_sequencer #(.UPDATE_DIV(50)) dut_thr (
    .clk(clk), .rst_n(rst_n), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .d_int(d_int2), .d_frac1(d_frac12), .d_frac2(d_frac22), .d_mv(d_mv2),
    .d_valid(d_valid2), .d_ready(d_ready2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present x, wait for the accept, then count edges until d_valid rises.
  task automatic start_and_wait(input logic [11:0] x, output int lat);
    int n;
    s_data  = x;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 60) begin tick(); n++; end
    chk("accept_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    lat = 0;
    while (!d_valid && lat < 40) begin tick(); lat++; end
  endtask

  task automatic check_result(input string tag, input int mv, input int lat);
    int e0, e1, e2;
    e0 = mv / 1000;
    e1 = (mv % 1000) / 100;
    e2 = (mv % 100) / 10;
    chk({tag, "_valid"}, d_valid, 1);
    chk({tag, "_latency"}, lat, 4 + e0 + e1 + e2);
    chk({tag, "_mv"}, d_mv, mv);
    chk({tag, "_int"}, d_int, e0);
    chk({tag, "_frac1"}, d_frac1, e1);
    chk({tag, "_frac2"}, d_frac2, e2);
  endtask

  initial begin
    int lat;
    int pulses;
    int x;
    int acc [8];
    int na;
    int nres;

    // Reset state
    #2;
    chk("rst_d_valid", d_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_d_mv", d_mv, 0);
    chk("rst_s_ready", s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 2048 -> 2500 mV, 2/5/0, 11 edges, valid drops one cycle after
    start_and_wait(12'd2048, lat);
    chk("c2048_latency_hand", lat, 11);
    chk("c2048_digits_hand", {d_int, d_frac1, d_frac2}, {4'd2, 4'd5, 4'd0});
    check_result("c2048", 2500, lat);
    tick();
    chk("c2048_valid_clear", d_valid, 0);
    chk("c2048_mv_kept", d_mv, 2500);

    // Reset mid-THOU with 4095 in flight
    s_data = 12'd4095;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    chk("midthou_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_d_mv", d_mv, 0);
    chk("arst_digits", {d_int, d_frac1, d_frac2}, 12'd0);
    chk("arst_d_valid", d_valid, 0);
    chk("arst_busy", busy, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready", s_ready, 1);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (d_valid) pulses++;
    end
    chk("aborted_no_valid", pulses, 0);

    // Extremes
    start_and_wait(12'd4095, lat);
    chk("c4095_latency_hand", lat, 26);
    check_result("c4095", 4998, lat);
    tick();
    start_and_wait(12'd0, lat);
    chk("c0_latency_hand", lat, 4);
    check_result("c0", 0, lat);
    tick();

    // Backpressure: 1000 -> 1220 held for 20 cycles, new sample refused
    d_ready = 1'b0;
    start_and_wait(12'd1000, lat);
    check_result("c1000", 1220, lat);
    s_data = 12'd2048;
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", d_valid, 1);
      chk("hold_mv", d_mv, 1220);
      chk("hold_digits", {d_int, d_frac1, d_frac2}, {4'd1, 4'd2, 4'd2});
      chk("hold_s_ready", s_ready, 0);
    end
    d_ready = 1'b1;
    tick();
    chk("release_valid_clear", d_valid, 0);
    chk("release_s_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    chk("next_accept_busy", busy, 1);
    chk("next_accept_mv_kept", d_mv, 1220);
    lat = 0;
    while (!d_valid && lat < 40) begin tick(); lat++; end
    check_result("after_hold", 2500, lat);
    tick();

    // Random sweep against the scaling model
    for (int k = 0; k < 16; k++) begin
      x = int'($urandom_range(0, 4095));
      start_and_wait(x[11:0], lat);
      check_result("sweep", (x * 5000) >> 12, lat);
      tick();
    end

    // Throttled instance: accepts exactly 50 cycles apart
    s_data2 = 12'd2048;
    s_valid2 = 1'b1;
    d_ready2 = 1'b1;
    na = 0;
    nres = 0;
    for (int i = 0; i < 160; i++) begin
      if (s_ready2 && na < 8) begin
        acc[na] = i;
        na++;
      end
      if (d_valid2) begin
        nres++;
        chk("thr_digits", {d_int2, d_frac12, d_frac22}, {4'd2, 4'd5, 4'd0});
        chk("thr_mv", d_mv2, 2500);
      end
      tick();
    end
    s_valid2 = 1'b0;
    chk("thr_accept_count", na, 4);
    chk("thr_result_count", nres, 3);
    for (int j = 1; j < 4; j++) begin
      if (j < na) chk("thr_spacing", acc[j] - acc[j-1], 50);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
